regfile_sb: RTL

- Parametrised successor to the team's 2-read/1-write register file.
- Adds configurable data width, register count and read-port count, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register pending (scoreboard) bit: the decode stage sets it on allocation; writeback clears it.
- Sits between decode (reads and allocation) and writeback (write port) in the CoE113 pipeline core.

---
 rtl/regfile_sb.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read, single-write register file with a
// per-register pending (scoreboard) bit. Decode reads operands and allocates
// destinations here; writeback writes results and retires pending bits.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              wr_ok;
  logic              alloc_ok;
  logic [ADDR_W-1:0] ra;

  // Register 0 is excluded from both writes and allocation when hardwired to zero.
  assign wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  // Data array: cleared on reset, written by the writeback port.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next pending vector: flush beats allocation, allocation beats retirement.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wr_ok) begin
        pend_d[wr_addr] = 1'b0;
      end
      if (alloc_ok) begin
        pend_d[alloc_addr] = 1'b1;
      end
    end
  end

  // Popcount of the next pending vector so the count register tracks pend_q exactly.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  // Scoreboard state and its registered occupancy count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // Combinational read ports: zero register, then write bypass, then stored state.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (nrst && !((ZERO_REG != 0) && (ra == '0))) begin
        if ((BYPASS != 0) && wr_en && (wr_addr == ra)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
          rd_busy[k]                  = pend_q[ra];
        end
      end
    end
  end

endmodule
